// File: rtl/zbt_sram_port.sv
// Single-port ZBT SRAM controller: arbitrates a write and a read request stream onto the
// SRAM pins with no turnaround cycles, delaying write data and capturing read data PIPE_LAT cycles later.
module zbt_sram_port #(
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 18,
  parameter int BYTE_LANES = 2,
  parameter int PIPE_LAT   = 2,
  parameter int ARB_MODE   = 0
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  WR_VALID,
  output logic                  WR_READY,
  input  logic [ADDR_WIDTH-1:0] WR_ADDR,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic [BYTE_LANES-1:0] WR_BE,
  input  logic                  RD_VALID,
  output logic                  RD_READY,
  input  logic [ADDR_WIDTH-1:0] RD_ADDR,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_DATA_VALID,
  output logic                  BUSY,
  output logic                  SRAM_CLK,
  output logic [ADDR_WIDTH-1:0] SRAM_ADD,
  inout  wire  [DATA_WIDTH-1:0] SRAM_DQ,
  output logic                  SRAM_ADV_LD_N,
  output logic [BYTE_LANES-1:0] SRAM_BW_N,
  output logic                  SRAM_CE_N,
  output logic                  SRAM_OE_N,
  output logic                  SRAM_WE_N
);

  // Handshake: a request is taken on a rising edge where VALID and READY are both high.
  // READY is combinational from the valids and the last-granted flag, at most one per cycle.
  logic                  wr_grant;
  logic                  rd_grant;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  last_rd;

  logic [PIPE_LAT:0]     wr_v;
  logic [PIPE_LAT:0]     rd_v;
  logic [DATA_WIDTH-1:0] wd [0:PIPE_LAT];

  logic [ADDR_WIDTH-1:0] add_q;
  logic                  ce_n_q;
  logic                  we_n_q;
  logic [BYTE_LANES-1:0] bw_n_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_dv_q;

  always_comb begin
    wr_grant = 1'b0;
    rd_grant = 1'b0;
    if (WR_VALID && (!RD_VALID || (ARB_MODE == 0) || last_rd)) begin
      wr_grant = 1'b1;
    end else if (RD_VALID) begin
      rd_grant = 1'b1;
    end
  end

  assign WR_READY = RESET_N & wr_grant;
  assign RD_READY = RESET_N & rd_grant;
  assign wr_acc   = WR_VALID & WR_READY;
  assign rd_acc   = RD_VALID & RD_READY;

  // Command stage: the pins carry the accepted command in the cycle after acceptance.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      add_q   <= '0;
      ce_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      bw_n_q  <= '1;
      last_rd <= 1'b1;
    end else begin
      ce_n_q <= ~(wr_acc | rd_acc);
      we_n_q <= ~wr_acc;
      bw_n_q <= '1;
      if (wr_acc) begin
        add_q   <= WR_ADDR;
        bw_n_q  <= ~WR_BE;
        last_rd <= 1'b0;
      end else if (rd_acc) begin
        add_q   <= RD_ADDR;
        bw_n_q  <= '0;
        last_rd <= 1'b1;
      end
    end
  end

  // Stage k of wr_v/rd_v/wd corresponds to cycle C+k; stage PIPE_LAT is the data cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_v      <= '0;
      rd_v      <= '0;
      rd_data_q <= '0;
      rd_dv_q   <= 1'b0;
      for (int k = 0; k <= PIPE_LAT; k++) begin
        wd[k] <= '0;
      end
    end else begin
      wr_v    <= {wr_v[PIPE_LAT-1:0], wr_acc};
      rd_v    <= {rd_v[PIPE_LAT-1:0], rd_acc};
      rd_dv_q <= rd_v[PIPE_LAT];
      if (wr_acc) begin
        wd[0] <= WR_DATA;
      end
      for (int k = 1; k <= PIPE_LAT; k++) begin
        wd[k] <= wd[k-1];
      end
      if (rd_v[PIPE_LAT]) begin
        rd_data_q <= SRAM_DQ;
      end
    end
  end

  // The output enable is the flopped write-valid of the data stage, so DQ drive is glitch-free.
  assign SRAM_DQ       = wr_v[PIPE_LAT] ? wd[PIPE_LAT] : {DATA_WIDTH{1'bz}};
  assign SRAM_OE_N     = ~rd_v[PIPE_LAT];
  assign SRAM_CLK      = CLK;
  assign SRAM_ADV_LD_N = 1'b0;
  assign SRAM_ADD      = add_q;
  assign SRAM_CE_N     = ce_n_q;
  assign SRAM_WE_N     = we_n_q;
  assign SRAM_BW_N     = bw_n_q;
  assign RD_DATA       = rd_data_q;
  assign RD_DATA_VALID = rd_dv_q;
  assign BUSY          = (|wr_v) | (|rd_v) | rd_dv_q;

endmodule

// File: tb/tb_zbt_sram_port.sv
// Directed bench for zbt_sram_port: default pipelined instance with an SRAM model, plus a
// round-robin instance and a flow-through instance exercised by hand-written sequences.
module tb_zbt_sram_port;
  localparam int AW = 23;
  localparam int DW = 18;
  localparam int BL = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int rv_count = 0;
  logic mon_oe_en = 1'b0;
  logic [DW-1:0] exp_q[$];

  // shared request payload
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic [BL-1:0] wr_be;

  // main instance (write priority, PIPE_LAT=2)
  logic wr_valid, wr_ready, rd_valid, rd_ready, rd_dv, busy, sram_clk, adv_n, ce_n, oe_n, we_n;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] sram_add;
  logic [BL-1:0] bw_n;
  wire  [DW-1:0] sram_dq;

  zbt_sram_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_LANES(BL), .PIPE_LAT(2), .ARB_MODE(0)) dut (
    .CLK(clk), .RESET_N(rst_n), .WR_VALID(wr_valid), .WR_READY(wr_ready), .WR_ADDR(wr_addr),
    .WR_DATA(wr_data), .WR_BE(wr_be), .RD_VALID(rd_valid), .RD_READY(rd_ready), .RD_ADDR(rd_addr),
    .RD_DATA(rd_data), .RD_DATA_VALID(rd_dv), .BUSY(busy), .SRAM_CLK(sram_clk), .SRAM_ADD(sram_add),
    .SRAM_DQ(sram_dq), .SRAM_ADV_LD_N(adv_n), .SRAM_BW_N(bw_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .SRAM_WE_N(we_n));

  // round-robin instance
  logic rr_wr_valid, rr_wr_ready, rr_rd_valid, rr_rd_ready, rr_rd_dv, rr_busy, rr_sram_clk;
  logic rr_adv_n, rr_ce_n, rr_oe_n, rr_we_n;
  logic [DW-1:0] rr_rd_data;
  logic [AW-1:0] rr_add;
  logic [BL-1:0] rr_bw_n;
  wire  [DW-1:0] rr_dq;

  zbt_sram_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_LANES(BL), .PIPE_LAT(2), .ARB_MODE(1)) dut_rr (
    .CLK(clk), .RESET_N(rst_n), .WR_VALID(rr_wr_valid), .WR_READY(rr_wr_ready), .WR_ADDR(wr_addr),
    .WR_DATA(wr_data), .WR_BE(wr_be), .RD_VALID(rr_rd_valid), .RD_READY(rr_rd_ready), .RD_ADDR(rd_addr),
    .RD_DATA(rr_rd_data), .RD_DATA_VALID(rr_rd_dv), .BUSY(rr_busy), .SRAM_CLK(rr_sram_clk),
    .SRAM_ADD(rr_add), .SRAM_DQ(rr_dq), .SRAM_ADV_LD_N(rr_adv_n), .SRAM_BW_N(rr_bw_n),
    .SRAM_CE_N(rr_ce_n), .SRAM_OE_N(rr_oe_n), .SRAM_WE_N(rr_we_n));

  // flow-through instance
  logic p1_wr_valid, p1_wr_ready, p1_rd_valid, p1_rd_ready, p1_rd_dv, p1_busy, p1_sram_clk;
  logic p1_adv_n, p1_ce_n, p1_oe_n, p1_we_n;
  logic [DW-1:0] p1_rd_data;
  logic [AW-1:0] p1_add;
  logic [BL-1:0] p1_bw_n;
  wire  [DW-1:0] p1_dq;
  logic p1_tb_drv = 1'b0;
  logic [DW-1:0] p1_tb_val = '0;

  zbt_sram_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_LANES(BL), .PIPE_LAT(1), .ARB_MODE(0)) dut_p1 (
    .CLK(clk), .RESET_N(rst_n), .WR_VALID(p1_wr_valid), .WR_READY(p1_wr_ready), .WR_ADDR(wr_addr),
    .WR_DATA(wr_data), .WR_BE(wr_be), .RD_VALID(p1_rd_valid), .RD_READY(p1_rd_ready), .RD_ADDR(rd_addr),
    .RD_DATA(p1_rd_data), .RD_DATA_VALID(p1_rd_dv), .BUSY(p1_busy), .SRAM_CLK(p1_sram_clk),
    .SRAM_ADD(p1_add), .SRAM_DQ(p1_dq), .SRAM_ADV_LD_N(p1_adv_n), .SRAM_BW_N(p1_bw_n),
    .SRAM_CE_N(p1_ce_n), .SRAM_OE_N(p1_oe_n), .SRAM_WE_N(p1_we_n));

  assign p1_dq = p1_tb_drv ? p1_tb_val : {DW{1'bz}};

  // pipelined SRAM model: command seen at cycle C, data on the bus at cycle C+2
  logic [DW-1:0] mem [0:255];
  logic m_rd0 = 1'b0, m_rd1 = 1'b0, m_wr0 = 1'b0, m_wr1 = 1'b0;
  logic [AW-1:0] m_a0, m_a1;
  logic [BL-1:0] m_bw0, m_bw1;

  always @(posedge clk) begin
    m_rd0 <= !ce_n && we_n;
    m_wr0 <= !ce_n && !we_n;
    m_a0  <= sram_add;
    m_bw0 <= bw_n;
    m_rd1 <= m_rd0;
    m_wr1 <= m_wr0;
    m_a1  <= m_a0;
    m_bw1 <= m_bw0;
    if (m_wr1) begin
      if (!m_bw1[0]) mem[m_a1[7:0]][8:0]  <= sram_dq[8:0];
      if (!m_bw1[1]) mem[m_a1[7:0]][17:9] <= sram_dq[17:9];
    end
  end

  assign sram_dq = m_rd1 ? mem[m_a1[7:0]] : {DW{1'bz}};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // read-return scoreboard and bus-ownership check against the model
  always @(negedge clk) begin
    if (rd_dv) begin
      rv_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rd_valid: got rd_data %0h expected no pulse (t=%0t)", rd_data, $time);
      end else begin
        chk("rd_data_sb", rd_data, exp_q.pop_front());
      end
    end
    if (mon_oe_en) chk("oe_n_vs_model", oe_n, !m_rd1);
  end

  typedef struct {
    logic          is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BL-1:0] be;
    logic [BL-1:0] exp_bw_n;
    logic [DW-1:0] exp_rd;
  } cmd_vec_t;

  cmd_vec_t vecs [8];

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    cmd_vec_t v;
    int wc, rc, rv0;

    vecs[0] = '{1'b1, 23'h10, 18'h1A5A5, 2'b11, 2'b00, 18'h0};
    vecs[1] = '{1'b0, 23'h10, 18'h0,     2'b00, 2'b00, 18'h1A5A5};
    vecs[2] = '{1'b1, 23'h20, 18'h2BCDE, 2'b01, 2'b10, 18'h0};
    vecs[3] = '{1'b0, 23'h20, 18'h0,     2'b00, 2'b00, 18'h000DE};
    vecs[4] = '{1'b1, 23'h20, 18'h3FFFF, 2'b00, 2'b11, 18'h0};
    vecs[5] = '{1'b0, 23'h20, 18'h0,     2'b00, 2'b00, 18'h000DE};
    vecs[6] = '{1'b1, 23'h30, 18'h12345, 2'b10, 2'b01, 18'h0};
    vecs[7] = '{1'b0, 23'h30, 18'h0,     2'b00, 2'b00, 18'h12200};

    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst_n = 1'b0;
    wr_valid = 1'b1; rd_valid = 1'b1;
    rr_wr_valid = 1'b0; rr_rd_valid = 1'b0; p1_wr_valid = 1'b0; p1_rd_valid = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;

    // reset state
    adv(); adv();
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_rd_dv", rd_dv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ce_n", ce_n, 1);
    chk("rst_we_n", we_n, 1);
    chk("rst_oe_n", oe_n, 1);
    chk("rst_bw_n", bw_n, 2'b11);
    chk("rst_add", sram_add, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("adv_ld_n", adv_n, 0);
    wr_valid = 1'b0; rd_valid = 1'b0;
    rst_n = 1'b1;
    mon_oe_en = 1'b1;

    // single commands, one at a time
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      wr_valid = v.is_wr; rd_valid = !v.is_wr;
      wr_addr = v.addr; rd_addr = v.addr; wr_data = v.data; wr_be = v.be;
      smp();
      if (v.is_wr) chk("vec_wr_ready", wr_ready, 1);
      else chk("vec_rd_ready", rd_ready, 1);
      adv();
      wr_valid = 1'b0; rd_valid = 1'b0;
      if (!v.is_wr) exp_q.push_back(v.exp_rd);
      smp();
      chk("vec_ce_n", ce_n, 0);
      chk("vec_we_n", we_n, !v.is_wr);
      chk("vec_add", sram_add, v.addr);
      chk("vec_bw_n", bw_n, v.exp_bw_n);
      chk("vec_busy", busy, 1);
      adv(); smp();
      chk("vec_rd_dv_early", rd_dv, 0);
      adv(); smp();
      if (v.is_wr) chk("vec_dq", sram_dq, v.data);
      else chk("vec_oe_n_data", oe_n, 0);
      adv(); smp();
      chk("vec_rd_dv", rd_dv, !v.is_wr);
      if (!v.is_wr) chk("vec_rd_data", rd_data, v.exp_rd);
      chk("vec_oe_n_after", oe_n, 1);
      adv(); smp();
      chk("vec_busy_done", busy, 0);
      chk("vec_ce_n_idle", ce_n, 1);
      adv();
    end

    // alternating W,R every cycle, each read returning the word written just before it
    rv0 = rv_count;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        wr_valid = 1'b1; rd_valid = 1'b0;
        wr_addr = 23'h40 + 23'(i / 2); wr_data = 18'h10000 | 18'(i * 'h111); wr_be = 2'b11;
      end else begin
        wr_valid = 1'b0; rd_valid = 1'b1;
        rd_addr = 23'h40 + 23'(i / 2);
        exp_q.push_back(18'h10000 | 18'((i - 1) * 'h111));
      end
      smp();
      chk("alt_ready", (i % 2 == 0) ? wr_ready : rd_ready, 1);
      if (i > 0) begin
        chk("alt_ce_n", ce_n, 0);
        chk("alt_we_n", we_n, (i - 1) % 2);
      end
      adv();
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    smp(); chk("alt_ce_n_last", ce_n, 0);
    adv(); smp(); chk("alt_ce_n_idle", ce_n, 1);
    repeat (6) adv();
    chk("alt_rd_pulses", rv_count - rv0, 8);
    chk("alt_queue_empty", exp_q.size(), 0);

    // write priority with both requests held
    wc = 0; rc = 0;
    wr_valid = 1'b1; rd_valid = 1'b1;
    wr_addr = 23'h60; wr_data = 18'h2AAAA; wr_be = 2'b11; rd_addr = 23'h60;
    for (int i = 0; i < 6; i++) begin
      smp();
      if (wr_ready) wc++;
      if (rd_ready) rc++;
      adv();
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    chk("arb0_writes", wc, 6);
    chk("arb0_reads", rc, 0);
    repeat (6) adv();

    // round-robin: write first after reset, then alternate
    rr_wr_valid = 1'b1; rr_rd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      smp();
      chk("rr_wr_ready", rr_wr_ready, (i % 2 == 0));
      chk("rr_rd_ready", rr_rd_ready, (i % 2 == 1));
      adv();
    end
    rr_wr_valid = 1'b0; rr_rd_valid = 1'b0;
    repeat (6) adv();

    // flow-through: write data at cycle 2, read valid at cycle 3
    p1_wr_valid = 1'b1; wr_addr = 23'h70; wr_data = 18'h15555; wr_be = 2'b11;
    smp(); chk("p1_wr_ready", p1_wr_ready, 1);
    adv(); p1_wr_valid = 1'b0;
    smp(); chk("p1_we_n", p1_we_n, 0);
    adv(); smp();
    chk("p1_dq", p1_dq, 18'h15555);
    chk("p1_oe_n_wr", p1_oe_n, 1);
    adv(); adv();
    p1_rd_valid = 1'b1; rd_addr = 23'h70;
    smp(); chk("p1_rd_ready", p1_rd_ready, 1);
    adv(); p1_rd_valid = 1'b0;
    smp();
    chk("p1_rd_ce_n", p1_ce_n, 0);
    chk("p1_rd_we_n", p1_we_n, 1);
    adv();
    p1_tb_val = 18'h0BEEF; p1_tb_drv = 1'b1;
    smp();
    chk("p1_oe_n_rd", p1_oe_n, 0);
    chk("p1_rd_dv_early", p1_rd_dv, 0);
    adv();
    p1_tb_drv = 1'b0;
    smp();
    chk("p1_rd_dv", p1_rd_dv, 1);
    chk("p1_rd_data", p1_rd_data, 18'h0BEEF);
    adv(); smp();
    chk("p1_rd_dv_once", p1_rd_dv, 0);
    adv();

    // reset with three reads in flight
    mon_oe_en = 1'b0;
    rv0 = rv_count;
    rd_valid = 1'b1; rd_addr = 23'h10;
    for (int i = 0; i < 3; i++) begin
      smp(); chk("mid_rd_ready", rd_ready, 1);
      adv();
    end
    rd_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    wr_valid = 1'b1; rd_valid = 1'b1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_ce_n", ce_n, 1);
    chk("mid_we_n", we_n, 1);
    chk("mid_oe_n", oe_n, 1);
    chk("mid_bw_n", bw_n, 2'b11);
    chk("mid_rd_dv", rd_dv, 0);
    chk("mid_wr_ready", wr_ready, 0);
    chk("mid_rd_ready", rd_ready, 0);
    adv(); smp();
    chk("mid_busy_held", busy, 0);
    adv();
    rst_n = 1'b1;
    rd_valid = 1'b0;
    wr_addr = 23'h77; wr_data = 18'h01234; wr_be = 2'b01;
    smp(); chk("post_rst_wr_ready", wr_ready, 1);
    adv(); wr_valid = 1'b0;
    smp();
    chk("post_rst_we_n", we_n, 0);
    chk("post_rst_add", sram_add, 23'h77);
    chk("post_rst_bw_n", bw_n, 2'b10);
    repeat (8) adv();
    chk("mid_no_rd_pulse", rv_count - rv0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/zbt_sram_port.md
ZBT_SRAM_PORT -- requirements
Module: zbt_sram_port

Interface
REQ-001 Parameter ADDR_WIDTH, default 23: SRAM address width.
REQ-002 Parameter DATA_WIDTH, default 18: SRAM data bus width; SHALL be divisible by BYTE_LANES.
REQ-003 Parameter BYTE_LANES, default 2: number of byte-write lanes.
REQ-004 Parameter PIPE_LAT, default 2: SRAM cycles from command at pins to data at pins; legal values are 1 (flow-through) and 2 (pipelined).
REQ-005 Parameter ARB_MODE, default 0: 0 = write priority, 1 = round-robin.
REQ-006 CLK  in  1  single clock; all logic is on its rising edge and SRAM_CLK is forwarded from it.
REQ-007 RESET_N  in  1  asynchronous active-low reset.
REQ-008 WR_VALID / WR_READY  in/out  1/1  write request handshake.
REQ-009 WR_ADDR  in  ADDR_WIDTH  write address.
REQ-010 WR_DATA  in  DATA_WIDTH  write data.
REQ-011 WR_BE  in  BYTE_LANES  active-high byte enables.
REQ-012 RD_VALID / RD_READY  in/out  1/1  read request handshake.
REQ-013 RD_ADDR  in  ADDR_WIDTH  read address.
REQ-014 RD_DATA / RD_DATA_VALID  out  DATA_WIDTH/1  read return; there is no backpressure on this path.
REQ-015 BUSY  out  1  high while any accepted command has not completed.
REQ-016 SRAM_CLK, SRAM_ADD[ADDR_WIDTH], SRAM_DQ inout[DATA_WIDTH], SRAM_ADV_LD_N, SRAM_BW_N[BYTE_LANES], SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  SRAM pins.

Function
REQ-017 At most one command SHALL be accepted per cycle; a command is accepted when VALID and READY are both high at a rising edge.
REQ-018 Ready SHALL be combinational from the valids and the arbiter state: RD_READY = RD_VALID and not granted-write; WR_READY = WR_VALID and not granted-read.
REQ-019 ARB_MODE=0, both valid: the write is granted.
REQ-020 ARB_MODE=1, both valid: the grant goes to the type not granted last; after reset the last-granted type is read, so write wins first.
REQ-021 The accepted command SHALL appear on SRAM_ADD/SRAM_WE_N/SRAM_CE_N/SRAM_BW_N one cycle after acceptance (cycle C), from registered outputs.
REQ-022 Idle cycle at the pins: SRAM_CE_N=1 and SRAM_WE_N=1.
REQ-023 SRAM_ADV_LD_N SHALL be tied 0; no bursts are issued.
REQ-024 SRAM_BW_N = ~WR_BE for writes and all-zero for reads.
REQ-025 Write data SHALL be delayed through a PIPE_LAT-deep shift register and driven on SRAM_DQ during cycle C+PIPE_LAT only; SRAM_DQ is high-Z in every other cycle.
REQ-026 The DQ output enable SHALL be a registered signal.
REQ-027 SRAM_OE_N SHALL be 0 in cycles where read data is expected and 1 otherwise.
REQ-028 Read data present at cycle C+PIPE_LAT SHALL be captured into an input register at the end of that cycle.
REQ-029 RD_DATA/RD_DATA_VALID SHALL present the captured data at cycle C+PIPE_LAT+1, which is acceptance + PIPE_LAT + 2 cycles, with RD_DATA_VALID high for exactly 1 cycle per read.
REQ-030 Back-to-back mixed reads and writes SHALL run with no idle cycles (ZBT, no turnaround), and the bus SHALL never be driven by both sides in the same cycle.
REQ-031 Read-after-write to the same address is ordered by issue order; the block does no reordering.
REQ-032 BUSY SHALL be high from the acceptance edge until the last pipeline stage of every outstanding command has drained; it is implemented as an OR of the pipeline valid bits.
REQ-033 Addresses SHALL be passed unmodified; no wrap or range check is performed.
REQ-034 A write with WR_BE=0 SHALL still issue a cycle with SRAM_BW_N all-ones (a no-op write).

Reset
REQ-035 While RESET_N=0, asynchronously: WR_READY=RD_READY=0, RD_DATA_VALID=0, BUSY=0, SRAM_CE_N=1, SRAM_WE_N=1, SRAM_OE_N=1, SRAM_BW_N all-ones, SRAM_DQ high-Z, all pipeline valid bits 0, RD_DATA=0, SRAM_ADD=0.
REQ-036 Reset asserted mid-operation SHALL discard all in-flight commands; no RD_DATA_VALID pulse for them SHALL occur after release.
REQ-037 After release, the first acceptance is possible on the first rising edge.

Verification
REQ-038 Single write with PIPE_LAT=2 (addr 0x000010, data 0x1A5A5, BE=2'b11) accepted at cycle 0 -> cycle 1: SRAM_WE_N=0, SRAM_ADD=0x10, SRAM_BW_N=00; cycle 3: SRAM_DQ=0x1A5A5; high-Z at cycles 2 and 4.
REQ-039 Read of addr 0x10 accepted at cycle 0, SRAM model returning 0x1A5A5 -> RD_DATA_VALID=1 with RD_DATA=0x1A5A5 at cycle 4 only; SRAM_OE_N=0 at cycle 3.
REQ-040 Alternating W,R,W,R every cycle for 16 cycles -> 16 commands at the pins in 16 consecutive cycles; no bus contention; 8 RD_DATA_VALID pulses with correct data.
REQ-041 WR_VALID=RD_VALID=1 held for 6 cycles -> ARB_MODE=0: 6 writes accepted, 0 reads; ARB_MODE=1: grant order W,R,W,R,W,R.
REQ-042 RESET_N pulled low 1 cycle after 3 reads are accepted -> no RD_DATA_VALID pulse; BUSY=0 and all SRAM control pins inactive immediately.
REQ-043 PIPE_LAT=1 single write and read -> write data driven at cycle 2; RD_DATA_VALID at cycle 3.
